// File: rtl/rs_pkg.sv
// Shared width constants for the integer reservation station and its neighbours.
package rs_pkg;
  localparam int ROB_POS_WID = 4;
  localparam int DATA_WID    = 32;
  localparam int OPCODE_WID  = 7;
  localparam int FUNCT3_WID  = 3;
  localparam int ADDR_WID    = 32;
endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-set-bit finder: reports whether any request bit is set and the index of the lowest one.
module rs_prio_enc #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);
  always_comb begin
    found = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end
endmodule

// File: rtl/rs.sv
// Integer ALU reservation station: buffers dispatched instructions, captures operands
// from the ALU/LSB broadcast buses and issues the lowest-index ready entry each cycle.
module rs
  import rs_pkg::*;
#(
  parameter int RS_SIZE   = 16,
  parameter int RS_IDX_W  = 4,
  parameter int ROB_POS_W = ROB_POS_WID
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  rollback,
  input  logic                  issue,
  input  logic [ROB_POS_W-1:0]  iss_rob_pos,
  input  logic [OPCODE_WID-1:0] iss_opcode,
  input  logic [FUNCT3_WID-1:0] iss_funct3,
  input  logic                  iss_funct7,
  input  logic                  iss_rs1_rdy,
  input  logic [DATA_WID-1:0]   iss_rs1_val,
  input  logic [ROB_POS_W-1:0]  iss_rs1_dep,
  input  logic                  iss_rs2_rdy,
  input  logic [DATA_WID-1:0]   iss_rs2_val,
  input  logic [ROB_POS_W-1:0]  iss_rs2_dep,
  input  logic [DATA_WID-1:0]   iss_imm,
  input  logic [ADDR_WID-1:0]   iss_pc,
  input  logic                  alu_result,
  input  logic [ROB_POS_W-1:0]  alu_result_rob_pos,
  input  logic [DATA_WID-1:0]   alu_result_val,
  input  logic                  lsb_result,
  input  logic [ROB_POS_W-1:0]  lsb_result_rob_pos,
  input  logic [DATA_WID-1:0]   lsb_result_val,
  output logic                  rs_nxt_full,
  output logic                  alu_en,
  output logic [ROB_POS_W-1:0]  alu_rob_pos,
  output logic [OPCODE_WID-1:0] alu_opcode,
  output logic [FUNCT3_WID-1:0] alu_funct3,
  output logic                  alu_funct7,
  output logic [DATA_WID-1:0]   alu_val1,
  output logic [DATA_WID-1:0]   alu_val2,
  output logic [DATA_WID-1:0]   alu_imm,
  output logic [ADDR_WID-1:0]   alu_pc
);
  // Handshake: issue is a one-cycle write strobe taken at any edge with rdy && !rollback;
  // the dispatcher must watch rs_nxt_full. alu_en is a one-cycle registered strobe with no
  // back-pressure; it holds with rdy low because the ALU holds too.
  localparam int CNT_W = RS_IDX_W + 2;

  logic [RS_SIZE-1:0]    busy, rdy1, rdy2;
  logic [DATA_WID-1:0]   val1 [RS_SIZE];
  logic [DATA_WID-1:0]   val2 [RS_SIZE];
  logic [DATA_WID-1:0]   imm_q [RS_SIZE];
  logic [ADDR_WID-1:0]   pc_q [RS_SIZE];
  logic [ROB_POS_W-1:0]  dep1 [RS_SIZE];
  logic [ROB_POS_W-1:0]  dep2 [RS_SIZE];
  logic [ROB_POS_W-1:0]  rob_q [RS_SIZE];
  logic [OPCODE_WID-1:0] op_q [RS_SIZE];
  logic [FUNCT3_WID-1:0] f3_q [RS_SIZE];
  logic [RS_SIZE-1:0]    f7_q;

  logic                free_found, sel_found;
  logic [RS_IDX_W-1:0] free_idx, sel_idx;
  logic [CNT_W-1:0]    busy_cnt, nxt_cnt;
  logic                in_rdy1, in_rdy2;
  logic [DATA_WID-1:0] in_val1, in_val2;

  rs_prio_enc #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_free_enc (
    .req(~busy), .found(free_found), .idx(free_idx)
  );

  rs_prio_enc #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_sel_enc (
    .req(busy & rdy1 & rdy2), .found(sel_found), .idx(sel_idx)
  );

  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < RS_SIZE; i++) busy_cnt = busy_cnt + CNT_W'(busy[i]);
    nxt_cnt     = busy_cnt + CNT_W'(issue) - CNT_W'(sel_found);
    rs_nxt_full = (nxt_cnt == CNT_W'(RS_SIZE));
  end

  // Same-cycle capture for an incoming instruction; ALU bus wins over LSB.
  always_comb begin
    in_rdy1 = iss_rs1_rdy;
    in_val1 = iss_rs1_val;
    in_rdy2 = iss_rs2_rdy;
    in_val2 = iss_rs2_val;
    if (!iss_rs1_rdy) begin
      if (alu_result && alu_result_rob_pos == iss_rs1_dep) begin
        in_rdy1 = 1'b1;
        in_val1 = alu_result_val;
      end else if (lsb_result && lsb_result_rob_pos == iss_rs1_dep) begin
        in_rdy1 = 1'b1;
        in_val1 = lsb_result_val;
      end
    end
    if (!iss_rs2_rdy) begin
      if (alu_result && alu_result_rob_pos == iss_rs2_dep) begin
        in_rdy2 = 1'b1;
        in_val2 = alu_result_val;
      end else if (lsb_result && lsb_result_rob_pos == iss_rs2_dep) begin
        in_rdy2 = 1'b1;
        in_val2 = lsb_result_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= '0;
      rdy1        <= '0;
      rdy2        <= '0;
      alu_en      <= 1'b0;
      alu_rob_pos <= '0;
      alu_opcode  <= '0;
      alu_funct3  <= '0;
      alu_funct7  <= 1'b0;
      alu_val1    <= '0;
      alu_val2    <= '0;
      alu_imm     <= '0;
      alu_pc      <= '0;
    end else if (rollback) begin
      busy   <= '0;
      alu_en <= 1'b0;
    end else if (rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i] && !rdy1[i]) begin
          if (alu_result && alu_result_rob_pos == dep1[i]) begin
            rdy1[i] <= 1'b1;
            val1[i] <= alu_result_val;
          end else if (lsb_result && lsb_result_rob_pos == dep1[i]) begin
            rdy1[i] <= 1'b1;
            val1[i] <= lsb_result_val;
          end
        end
        if (busy[i] && !rdy2[i]) begin
          if (alu_result && alu_result_rob_pos == dep2[i]) begin
            rdy2[i] <= 1'b1;
            val2[i] <= alu_result_val;
          end else if (lsb_result && lsb_result_rob_pos == dep2[i]) begin
            rdy2[i] <= 1'b1;
            val2[i] <= lsb_result_val;
          end
        end
      end

      alu_en <= sel_found;
      if (sel_found) begin
        busy[sel_idx] <= 1'b0;
        alu_rob_pos   <= rob_q[sel_idx];
        alu_opcode    <= op_q[sel_idx];
        alu_funct3    <= f3_q[sel_idx];
        alu_funct7    <= f7_q[sel_idx];
        alu_val1      <= val1[sel_idx];
        alu_val2      <= val2[sel_idx];
        alu_imm       <= imm_q[sel_idx];
        alu_pc        <= pc_q[sel_idx];
      end

      // The free slot is not busy, so neither wakeup nor select touches it this edge.
      if (issue && free_found) begin
        busy[free_idx]  <= 1'b1;
        rdy1[free_idx]  <= in_rdy1;
        val1[free_idx]  <= in_val1;
        dep1[free_idx]  <= iss_rs1_dep;
        rdy2[free_idx]  <= in_rdy2;
        val2[free_idx]  <= in_val2;
        dep2[free_idx]  <= iss_rs2_dep;
        rob_q[free_idx] <= iss_rob_pos;
        op_q[free_idx]  <= iss_opcode;
        f3_q[free_idx]  <= iss_funct3;
        f7_q[free_idx]  <= iss_funct7;
        imm_q[free_idx] <= iss_imm;
        pc_q[free_idx]  <= iss_pc;
      end
    end
  end
endmodule

// File: doc/rs.md
# rs

Reservation station for the integer ALU. It buffers up to `RS_SIZE` decoded instructions from the dispatcher and captures missing operands from the two result broadcast buses (ALU, LSB). Each cycle it issues at most one fully-ready entry to the ALU through a registered one-cycle strobe. It sits between the dispatcher/ROB-allocation stage and the ALU, and is flushed by `rollback`.

## Interface
- `RS_SIZE`, 16, number of entries (power of two, ≥2)
- `RS_IDX_W`, 4, log2(`RS_SIZE`)
- `ROB_POS_W`, 4, ROB index width (matches `ROB_POS_WID`)

- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `rdy` in 1: global enable; when low, all state and outputs hold
- `rollback` in 1: mispredict flush
- `issue` in 1: dispatcher writes one instruction this cycle
- `iss_rob_pos` in `ROB_POS_W`: destination ROB entry
- `iss_opcode` in 7, `iss_funct3` in 3, `iss_funct7` in 1 (instr bit 30)
- `iss_rs1_rdy`, `iss_rs2_rdy` in 1: operand value already known
- `iss_rs1_val`, `iss_rs2_val` in 32: value when ready
- `iss_rs1_dep`, `iss_rs2_dep` in `ROB_POS_W`: producer ROB entry when not ready
- `iss_imm` in 32, `iss_pc` in 32
- `alu_result` in 1, `alu_result_rob_pos` in `ROB_POS_W`, `alu_result_val` in 32: ALU broadcast
- `lsb_result` in 1, `lsb_result_rob_pos` in `ROB_POS_W`, `lsb_result_val` in 32: LSB broadcast
- `rs_nxt_full` out 1: combinational; no free entry after the coming edge
- `alu_en` out 1: registered one-cycle issue strobe
- `alu_rob_pos` out `ROB_POS_W`, `alu_opcode` out 7, `alu_funct3` out 3, `alu_funct7` out 1
- `alu_val1`, `alu_val2`, `alu_imm`, `alu_pc` out 32

## Operation
- Entry state: `busy`, `rdy1`/`val1`/`dep1`, `rdy2`/`val2`/`dep2`, plus opcode, funct3, funct7, imm, pc, and rob_pos.
- Operands with no source register (LUI, AUIPC, JAL; rs2 of OP-IMM, JALR) arrive with `rdy`=1 from the dispatcher. The RS does not decode opcodes.
- **Issue:** written into the lowest-index entry with `busy`=0 in the current state. If an operand is not ready and its `dep` matches a valid broadcast in the same cycle, the broadcast value is stored with `rdy`=1. ALU is checked before LSB; both matching the same dep is illegal.
- **Wakeup:** at each edge, every busy entry compares each not-ready `dep` against both buses. On a match it stores the value and sets `rdy`.
- **Select:** the lowest-index entry with `busy`, `rdy1`, and `rdy2` all set in the current state is chosen. At the edge it is copied to the `alu_*` registers, `alu_en`<=1, and its `busy` is cleared. With no candidate, `alu_en`<=0 and the `alu_*` data registers hold.
- An entry woken at edge N is eligible for select at edge N+1. There is no same-cycle wake-and-issue.
- A slot freed by select at edge N is not reused by an issue at edge N, because the free-slot search uses the current state.
- `rs_nxt_full` = (busy count + `issue` − select_valid) == `RS_SIZE`.
- `issue` while all entries are busy is a protocol violation. The write is dropped and the bench flags it.
- **rollback (with `rdy`):** all `busy` cleared and `alu_en`<=0 at that edge. An issue in the same cycle is discarded.

## Timing
- Reset: all `busy`=0, `alu_en`=0, every `alu_*` output 0, and `rs_nxt_full` reads 0.
- `rst` and `rollback` take priority over `rdy`, matching the ALU's reset branch.
- With `rdy`=0, everything holds, including `alu_en`. The ALU also holds, so the strobe is consumed once.
- Minimum latency from issue to `alu_en`:
  - Ready operands: `issue` at edge N, `alu_en` high during N+1..N+2, ALU result after edge N+2.
  - Dependent operand: broadcast at edge M makes the entry issuable at edge M+1.
- Throughput is one instruction per cycle.
- Simultaneous issue, wakeup, and select in one cycle are all legal and independent.
- `rob_pos` 0 is a valid dependency. The `rdy` flags, not sentinel values, mark validity.

## Structure
- The shared width/opcode header holds `ROB_POS_WID`, `DATA_WID`, `OPCODE_WID`, `FUNCT3_WID`, and `ADDR_WID`. No new constants are needed.
- One sub-module, `rs_prio_enc`: a `RS_SIZE`-bit lowest-set-bit finder with outputs `found` and `idx`. It is instantiated twice, once for the free-slot search and once for the ready-entry select.

## Test plan
- **Single ready ADDI:** issue rob 3, val1=5, imm=7, both ready at edge 0 → `alu_en`=1 after edge 1 with rob 3, val1 5, imm 7, and `rs_nxt_full`=0.
- **Dependency wakeup:** issue rob 2 with rs1 dep=1. ALU broadcast rob 1 with val 0x10 at edge 4 → `alu_en` for rob 2 after edge 5 with val1=0x10, and not earlier.
- **Same-cycle capture:** issue with dep=6 while `lsb_result` rob 6 val 0xAB is asserted → entry stored ready, and issued at the next edge with val1=0xAB.
- **Full:** 16 issues with unresolved deps → `rs_nxt_full`=1 during the 16th issue cycle. One broadcast wakes entry 0 → after its select, `rs_nxt_full` falls.
- **Priority and ordering:** entries 0, 5, and 9 ready at once → issued in order 0, 5, 9 on three consecutive edges.
- **Rollback and rdy:**
  - 8 busy entries, `rollback` with `issue` and a ready entry present → all cleared, `alu_en`=0, and no later `alu_en`.
  - `rdy` low for 3 cycles with `alu_en`=1 → `alu_en` stays 1 and does not repeat once `rdy` returns.
